// File: rtl/data_mem_port_ctrl_pkg.sv
// Shared types and helpers for the data-memory port controller:
// RV32 width codes, the FSM state enum and the store lane-steering functions.
package data_mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [31:0] DEFAULT_MMIO_ADDR = 32'h0000_0FFC;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RESP
  } state_e;

  // Byte-lane write enables for a store of width f3 at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: lane_mask = 4'b0001 << off;
      F3_H, F3_HU: lane_mask = 4'b0011 << off;
      F3_W:        lane_mask = 4'b1111;
      default:     lane_mask = 4'b0000;
    endcase
  endfunction

  // Replicate right-justified store data across every lane it could land in.
  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3)
      F3_B, F3_BU: lane_data = {4{wdata[7:0]}};
      F3_H, F3_HU: lane_data = {2{wdata[15:0]}};
      F3_W:        lane_data = wdata;
      default:     lane_data = '0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_port_ctrl_if.sv
// Request/response handshake, BRAM port-B and MMIO signals of the controller.
interface data_mem_port_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned NUM_COL    = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  mem_en;
  logic [NUM_COL-1:0]    mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic [31:0]           mmio_dout;

  // master: CPU memory stage plus the BRAM that answers port B.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_en, mem_we, mem_addr, mem_wdata, mmio_dout
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_en, mem_we, mem_addr, mem_wdata, mmio_dout
  );
endinterface

// File: rtl/data_mem_port_ctrl_load_formatter.sv
// Selects the addressed byte/half/word from a BRAM read word and extends it.
module load_formatter
  import data_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0, half_sel};
      F3_W:    result = rdata;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_port_ctrl.sv
// Load/store initiator on BRAM port B: legality checks, lane steering,
// load formatting on the one-cycle-late read data and the MMIO output word.
module data_mem_port_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned NUM_COL    = 4,
  parameter logic [31:0] MMIO_ADDR  = DEFAULT_MMIO_ADDR
) (
  input logic                clk,
  input logic                reset_n,
  data_mem_port_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mmio_q, mmio_d;

  logic                  req_ready;
  logic                  accept;
  logic                  f3_bad, misaligned, out_of_range, acc_err;
  logic                  mmio_hit;
  logic                  mem_en;
  logic [NUM_COL-1:0]    mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           fmt_data;

  // Gated by reset_n so the combinational BRAM controls stay quiet in reset.
  assign req_ready = reset_n && (state_q == IDLE);
  assign accept    = bus.req_valid && req_ready;

  always_comb begin
    f3_bad       = (bus.req_funct3 == 3'd3) || (bus.req_funct3 == 3'd6) || (bus.req_funct3 == 3'd7);
    misaligned   = ((bus.req_funct3 == F3_H || bus.req_funct3 == F3_HU) && bus.req_addr[0])
                || ((bus.req_funct3 == F3_W) && (bus.req_addr[1:0] != 2'b00));
    out_of_range = |bus.req_addr[31:ADDR_WIDTH+2];
    acc_err      = f3_bad || misaligned || out_of_range;
    mmio_hit     = bus.req_addr[ADDR_WIDTH+1:2] == MMIO_ADDR[ADDR_WIDTH+1:2];
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (accept && !acc_err) begin
      mem_en   = 1'b1;
      mem_addr = bus.req_addr[ADDR_WIDTH+1:2];
      if (bus.req_we) begin
        mem_we    = lane_mask(bus.req_funct3, bus.req_addr[1:0]);
        mem_wdata = lane_data(bus.req_funct3, bus.req_wdata);
      end
    end
  end

  load_formatter u_load_formatter (
    .rdata  (bus.mem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .result (fmt_data)
  );

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mmio_d  = mmio_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          off_d = bus.req_addr[1:0];
          f3_d  = bus.req_funct3;
          err_d = acc_err;
          if (acc_err || bus.req_we) begin
            state_d = RESP;
            rdata_d = '0;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        rdata_d = fmt_data;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (mem_en && mmio_hit) begin
      for (int unsigned i = 0; i < NUM_COL; i++) begin
        if (mem_we[i]) mmio_d[i*8 +: 8] = mem_wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      off_q   <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mmio_q  <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mmio_q  <= mmio_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mmio_dout = mmio_q;

endmodule

// File: tb/tb_data_mem_port_ctrl.sv
// Directed bench for data_mem_port_ctrl with a read-first BRAM port-B model.
module tb_data_mem_port_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  data_mem_port_ctrl_if #(.ADDR_WIDTH(13), .NUM_COL(4)) bus ();

  data_mem_port_ctrl #(
    .ADDR_WIDTH (13),
    .NUM_COL    (4),
    .MMIO_ADDR  (32'h0000_0FFC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [31:0] bram [0:8191] = '{default: '0};

  always @(posedge clk) begin
    if (bus.mem_en) begin
      bus.mem_rdata <= bram[bus.mem_addr];
      for (int i = 0; i < 4; i++)
        if (bus.mem_we[i]) bram[bus.mem_addr][i*8 +: 8] <= bus.mem_wdata[i*8 +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  // Called just after a rising edge with the controller idle.
  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic exp_en, input logic [3:0] exp_we,
                      input logic [31:0] exp_wdata, input int exp_lat,
                      input logic exp_err, input logic [31:0] exp_rdata);
    int   lat;
    logic got;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(negedge clk);
    check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, ".en"}, 32'(bus.mem_en), 32'(exp_en));
    check({tag, ".we"}, 32'(bus.mem_we), 32'(exp_we));
    if (exp_en) check({tag, ".addr"}, 32'(bus.mem_addr), 32'(addr[14:2]));
    if (exp_we != 4'h0) check({tag, ".wdata"}, bus.mem_wdata, exp_wdata);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 5) begin
      @(negedge clk);
      lat++;
      got = bus.rsp_valid;
      if (!got) check({tag, ".en_after"}, 32'(bus.mem_en), 32'd0);
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".err"}, 32'(bus.rsp_err), 32'(exp_err));
    check({tag, ".rdata"}, bus.rsp_rdata, exp_rdata);
    @(negedge clk);
    check({tag, ".pulse"}, 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    check("rst.en", 32'(bus.mem_en), 32'd0);
    check("rst.we", 32'(bus.mem_we), 32'd0);
    check("rst.valid", 32'(bus.rsp_valid), 32'd0);
    check("rst.err", 32'(bus.rsp_err), 32'd0);
    check("rst.rdata", bus.rsp_rdata, 32'd0);
    check("rst.mmio", bus.mmio_dout, 32'd0);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1 check("rst.ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;

    //   tag       we  f3    addr     wdata         en  we     mem_wdata     lat err rdata
    xact("sw10",   1, 3'd2, 32'h10,  32'hA5A5_1234, 1, 4'hF, 32'hA5A5_1234, 1, 0, 32'h0);
    xact("lw10",   0, 3'd2, 32'h10,  32'h0,         1, 4'h0, 32'h0,         2, 0, 32'hA5A5_1234);
    xact("sb13",   1, 3'd0, 32'h13,  32'h80,        1, 4'h8, 32'h8080_8080, 1, 0, 32'h0);
    xact("lb13",   0, 3'd0, 32'h13,  32'h0,         1, 4'h0, 32'h0,         2, 0, 32'hFFFF_FF80);
    xact("lbu13",  0, 3'd4, 32'h13,  32'h0,         1, 4'h0, 32'h0,         2, 0, 32'h0000_0080);
    xact("lw10b",  0, 3'd2, 32'h10,  32'h0,         1, 4'h0, 32'h0,         2, 0, 32'h80A5_1234);
    xact("sh22",   1, 3'd1, 32'h22,  32'hBEEF,      1, 4'hC, 32'hBEEF_BEEF, 1, 0, 32'h0);
    xact("lh22",   0, 3'd1, 32'h22,  32'h0,         1, 4'h0, 32'h0,         2, 0, 32'hFFFF_BEEF);
    xact("lhu22",  0, 3'd5, 32'h22,  32'h0,         1, 4'h0, 32'h0,         2, 0, 32'h0000_BEEF);
    xact("lw11",   0, 3'd2, 32'h11,  32'h0,         0, 4'h0, 32'h0,         1, 1, 32'h0);
    xact("sh21",   1, 3'd1, 32'h21,  32'h1111,      0, 4'h0, 32'h0,         1, 1, 32'h0);
    xact("f3ill",  1, 3'd3, 32'h30,  32'h2222,      0, 4'h0, 32'h0,         1, 1, 32'h0);
    xact("swoor",  1, 3'd2, 32'h8000, 32'h3333,     0, 4'h0, 32'h0,         1, 1, 32'h0);
    xact("lw20",   0, 3'd2, 32'h20,  32'h0,         1, 4'h0, 32'h0,         2, 0, 32'hBEEF_0000);
    xact("lw00",   0, 3'd2, 32'h0,   32'h0,         1, 4'h0, 32'h0,         2, 0, 32'h0);
    xact("lw30",   0, 3'd2, 32'h30,  32'h0,         1, 4'h0, 32'h0,         2, 0, 32'h0);
    xact("swmmio", 1, 3'd2, 32'hFFC, 32'hABCD_1234, 1, 4'hF, 32'hABCD_1234, 1, 0, 32'h0);
    check("mmio.sw", bus.mmio_dout, 32'hABCD_1234);
    xact("sbmmio", 1, 3'd0, 32'hFFC, 32'h55,        1, 4'h1, 32'h5555_5555, 1, 0, 32'h0);
    check("mmio.sb", bus.mmio_dout, 32'hABCD_1255);
    xact("lwmmio", 0, 3'd2, 32'hFFC, 32'h0,         1, 4'h0, 32'h0,         2, 0, 32'hABCD_1255);
    check("bram3ff", bram[13'h3FF], 32'hABCD_1255);

    // Abandon a load in RD_WAIT with an asynchronous reset.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 32'h10;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("mid.rdata", bus.rsp_rdata, 32'd0);
    check("mid.mmio", bus.mmio_dout, 32'd0);
    check("mid.en", 32'(bus.mem_en), 32'd0);
    check("mid.valid", 32'(bus.rsp_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid.novalid", 32'(bus.rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1 check("mid.ready", 32'(bus.req_ready), 32'd1);
    xact("lwpost", 0, 3'd2, 32'h10,  32'h0,         1, 4'h0, 32'h0,         2, 0, 32'h80A5_1234);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
